// File: rtl/bus8_pkg.sv
// Shared definitions for the bus8 arbiter family: state encoding, requester
// count and the read data returned when a slave never answers.
package bus8_pkg;
  localparam int N_REQ = 4;
  localparam int IDX_W = 2;
  localparam logic [7:0] BUS8_TIMEOUT_DATA = 8'hEE;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    DONE    = 2'd3
  } bus8_state_e;
endpackage

// File: rtl/bus8_arbiter_x4_if.sv
// Requester and bus-slave signal bundle for bus8_arbiter_x4; the master
// modport is the arbiter's view, the slave modport the environment's.
interface bus8_arbiter_x4_if;
  import bus8_pkg::*;

  logic [N_REQ-1:0]   i_Req;
  logic [N_REQ-1:0]   i_Req_Wr_Rd_n;
  logic [8*N_REQ-1:0] i_Req_Addr8;
  logic [8*N_REQ-1:0] i_Req_Wr_Data;
  logic [N_REQ-1:0]   o_Req_Done;
  logic [7:0]         o_Req_Rd_Data;
  logic               o_Req_Timeout;
  logic               o_Bus_CS;
  logic               o_Bus_Wr_Rd_n;
  logic [7:0]         o_Bus_Addr8;
  logic [7:0]         o_Bus_Wr_Data;
  logic [7:0]         i_Bus_Rd_Data;
  logic               i_Bus_Rd_DV;

  modport master (
    input  i_Req, i_Req_Wr_Rd_n, i_Req_Addr8, i_Req_Wr_Data,
    input  i_Bus_Rd_Data, i_Bus_Rd_DV,
    output o_Req_Done, o_Req_Rd_Data, o_Req_Timeout,
    output o_Bus_CS, o_Bus_Wr_Rd_n, o_Bus_Addr8, o_Bus_Wr_Data
  );

  modport slave (
    output i_Req, i_Req_Wr_Rd_n, i_Req_Addr8, i_Req_Wr_Data,
    output i_Bus_Rd_Data, i_Bus_Rd_DV,
    input  o_Req_Done, o_Req_Rd_Data, o_Req_Timeout,
    input  o_Bus_CS, o_Bus_Wr_Rd_n, o_Bus_Addr8, o_Bus_Wr_Data
  );
endinterface

// File: rtl/bus8_rr_pick.sv
// Combinational round-robin picker: the first set request found searching
// upward from i_last+1 (wrapping) wins.
module bus8_rr_pick
  import bus8_pkg::*;
(
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_last,
  output logic             o_vld,
  output logic [IDX_W-1:0] o_idx
);
  logic [IDX_W-1:0] cand;

  always_comb begin
    o_vld = 1'b0;
    o_idx = i_last;
    cand  = i_last;
    // Scan from lowest to highest priority so the nearest candidate overwrites.
    for (int i = N_REQ; i >= 1; i--) begin
      cand = i_last + IDX_W'(i);
      if (i_req[cand]) begin
        o_vld = 1'b1;
        o_idx = cand;
      end
    end
  end
endmodule

// File: rtl/bus8_arbiter_x4.sv
// Four-way round-robin arbiter/sequencer for the shared 8-bit register bus.
// Define BUS8_ARB_TIMEOUT_EN to abandon reads after TIMEOUT_CYCLES in WAIT_RD.
module bus8_arbiter_x4
  import bus8_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              i_Bus_Clk,
  input  logic              i_Bus_Rst_L,
  bus8_arbiter_x4_if.master bus
);
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be within 1..255");
  end

  bus8_state_e      state_q, state_d;
  logic [IDX_W-1:0] last_grant_q, last_grant_d;
  logic [IDX_W-1:0] win_q, win_d;
  logic             wr_q, wr_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic             cs_q, cs_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic [7:0]       rd_data_q, rd_data_d;
  logic             pick_vld;
  logic [IDX_W-1:0] pick_idx;
`ifdef BUS8_ARB_TIMEOUT_EN
  logic [7:0]       cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
`endif

  bus8_rr_pick u_pick (
    .i_req  (bus.i_Req),
    .i_last (last_grant_q),
    .o_vld  (pick_vld),
    .o_idx  (pick_idx)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    win_d        = win_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cs_d         = 1'b0;
    done_d       = '0;
    rd_data_d    = rd_data_q;
`ifdef BUS8_ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
    timeout_d    = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        // Latch the winner's fields so requester-side changes cannot disturb the bus.
        if (pick_vld) begin
          win_d        = pick_idx;
          last_grant_d = pick_idx;
          wr_d         = bus.i_Req_Wr_Rd_n[pick_idx];
          addr_d       = bus.i_Req_Addr8[{pick_idx, 3'b000} +: 8];
          wdata_d      = bus.i_Req_Wr_Data[{pick_idx, 3'b000} +: 8];
          cs_d         = 1'b1;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        if (wr_q) begin
          done_d[win_q] = 1'b1;
          state_d       = DONE;
        end else begin
          state_d = WAIT_RD;
`ifdef BUS8_ARB_TIMEOUT_EN
          cnt_d   = 8'd0;
`endif
        end
      end
      WAIT_RD: begin
        if (bus.i_Bus_Rd_DV) begin
          rd_data_d     = bus.i_Bus_Rd_Data;
          done_d[win_q] = 1'b1;
          state_d       = DONE;
        end
`ifdef BUS8_ARB_TIMEOUT_EN
        else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
          rd_data_d     = BUS8_TIMEOUT_DATA;
          timeout_d     = 1'b1;
          done_d[win_q] = 1'b1;
          state_d       = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_Bus_Clk or negedge i_Bus_Rst_L) begin
    if (!i_Bus_Rst_L) begin
      state_q      <= IDLE;
      last_grant_q <= IDX_W'(N_REQ - 1);
      win_q        <= '0;
      wr_q         <= 1'b0;
      addr_q       <= 8'd0;
      wdata_q      <= 8'd0;
      cs_q         <= 1'b0;
      done_q       <= '0;
      rd_data_q    <= 8'd0;
`ifdef BUS8_ARB_TIMEOUT_EN
      cnt_q        <= 8'd0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      win_q        <= win_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cs_q         <= cs_d;
      done_q       <= done_d;
      rd_data_q    <= rd_data_d;
`ifdef BUS8_ARB_TIMEOUT_EN
      cnt_q        <= cnt_d;
      timeout_q    <= timeout_d;
`endif
    end
  end

  assign bus.o_Bus_CS      = cs_q;
  assign bus.o_Bus_Wr_Rd_n = wr_q;
  assign bus.o_Bus_Addr8   = addr_q;
  assign bus.o_Bus_Wr_Data = wdata_q;
  assign bus.o_Req_Done    = done_q;
  assign bus.o_Req_Rd_Data = rd_data_q;
`ifdef BUS8_ARB_TIMEOUT_EN
  assign bus.o_Req_Timeout = timeout_q;
`else
  assign bus.o_Req_Timeout = 1'b0;
`endif
endmodule

// File: tb/tb_bus8_arbiter_x4.sv
// Directed bench for bus8_arbiter_x4 with a one-cycle 16-register file model
// answering addresses 8'h00..8'h0F; higher addresses have no slave.
`timescale 1ns/1ps
module tb_bus8_arbiter_x4;
  import bus8_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_miscmp = 0;

  bus8_arbiter_x4_if bif ();

  bus8_arbiter_x4 #(.TIMEOUT_CYCLES(4)) dut (
    .i_Bus_Clk   (clk),
    .i_Bus_Rst_L (rst_n),
    .bus         (bif)
  );

  always #5 clk = ~clk;

  logic [7:0] regs [16] = '{default: 8'h00};
  logic       mdl_dv     = 1'b0;
  logic [7:0] mdl_data   = 8'h00;
  logic       stray_dv   = 1'b0;
  logic [7:0] stray_data = 8'h00;

  assign bif.i_Bus_Rd_DV   = mdl_dv | stray_dv;
  assign bif.i_Bus_Rd_Data = stray_dv ? stray_data : mdl_data;

  always @(posedge clk) begin
    mdl_dv <= 1'b0;
    if (bif.o_Bus_CS && bif.o_Bus_Addr8 < 8'h10) begin
      if (bif.o_Bus_Wr_Rd_n) regs[bif.o_Bus_Addr8[3:0]] <= bif.o_Bus_Wr_Data;
      else begin
        mdl_dv   <= 1'b1;
        mdl_data <= regs[bif.o_Bus_Addr8[3:0]];
      end
    end
  end

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int n, input logic wr, input logic [7:0] a, input logic [7:0] d);
    bif.i_Req[n]            = 1'b1;
    bif.i_Req_Wr_Rd_n[n]    = wr;
    bif.i_Req_Addr8[8*n+:8]   = a;
    bif.i_Req_Wr_Data[8*n+:8] = d;
  endtask

  task automatic clr_req(input int n);
    bif.i_Req[n] = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  initial begin
    bif.i_Req         = '0;
    bif.i_Req_Wr_Rd_n = '0;
    bif.i_Req_Addr8   = '0;
    bif.i_Req_Wr_Data = '0;
    step(2);
    check_vec("rst_cs",   32'(bif.o_Bus_CS),      32'h0);
    check_vec("rst_done", 32'(bif.o_Req_Done),    32'h0);
    check_vec("rst_rd",   32'(bif.o_Req_Rd_Data), 32'h0);
    check_vec("rst_to",   32'(bif.o_Req_Timeout), 32'h0);
    check_vec("rst_bus",  32'({bif.o_Bus_Wr_Rd_n, bif.o_Bus_Addr8, bif.o_Bus_Wr_Data}), 32'h0);
    rst_n = 1'b1;

    // Requester 2 writes 5A to 03, then requester 1 reads it back.
    set_req(2, 1'b1, 8'h03, 8'h5A);
    step();
    check_vec("wr_cs",    32'(bif.o_Bus_CS),      32'h1);
    check_vec("wr_dir",   32'(bif.o_Bus_Wr_Rd_n), 32'h1);
    check_vec("wr_addr",  32'(bif.o_Bus_Addr8),   32'h03);
    check_vec("wr_data",  32'(bif.o_Bus_Wr_Data), 32'h5A);
    step();
    check_vec("wr_done",  32'(bif.o_Req_Done),    32'h4);
    check_vec("wr_cs_off",32'(bif.o_Bus_CS),      32'h0);
    clr_req(2);
    step();
    check_vec("wr_done_1cyc", 32'(bif.o_Req_Done), 32'h0);
    set_req(1, 1'b0, 8'h03, 8'h00);
    step();
    check_vec("rd_cs",    32'(bif.o_Bus_CS),      32'h1);
    check_vec("rd_dir",   32'(bif.o_Bus_Wr_Rd_n), 32'h0);
    step();
    check_vec("rd_nodone_c2", 32'(bif.o_Req_Done), 32'h0);
    step();
    check_vec("rd_done",  32'(bif.o_Req_Done),    32'h2);
    check_vec("rd_data",  32'(bif.o_Req_Rd_Data), 32'h5A);
    clr_req(1);
    step();
    check_vec("rd_done_1cyc", 32'(bif.o_Req_Done), 32'h0);

    // Stray DV in IDLE must be ignored.
    stray_dv = 1'b1; stray_data = 8'hFF;
    step();
    stray_dv = 1'b0;
    check_vec("stray_done", 32'(bif.o_Req_Done),    32'h0);
    step();
    check_vec("stray_rd",   32'(bif.o_Req_Rd_Data), 32'h5A);
    check_vec("stray_cs",   32'(bif.o_Bus_CS),      32'h0);

    // Read by 1 and write by 3 raised together; read first, no CS overlap.
    do_reset();
    set_req(1, 1'b0, 8'h03, 8'h00);
    set_req(3, 1'b1, 8'h09, 8'hC3);
    step();
    check_vec("mix_cs1",   32'(bif.o_Bus_CS),    32'h1);
    check_vec("mix_addr1", 32'(bif.o_Bus_Addr8), 32'h03);
    step();
    check_vec("mix_cs_c2", 32'(bif.o_Bus_CS),    32'h0);
    step();
    check_vec("mix_done1", 32'(bif.o_Req_Done),  32'h2);
    check_vec("mix_rd1",   32'(bif.o_Req_Rd_Data), 32'h5A);
    check_vec("mix_cs_c3", 32'(bif.o_Bus_CS),    32'h0);
    clr_req(1);
    step();
    check_vec("mix_cs_c4", 32'(bif.o_Bus_CS),    32'h0);
    step();
    check_vec("mix_cs3",   32'(bif.o_Bus_CS),    32'h1);
    check_vec("mix_addr3", 32'(bif.o_Bus_Addr8), 32'h09);
    check_vec("mix_dir3",  32'(bif.o_Bus_Wr_Rd_n), 32'h1);
    step();
    check_vec("mix_done3", 32'(bif.o_Req_Done),  32'h8);
    clr_req(3);
    step();

    // All four requesters continuously after reset: 0,1,2,3,0,1.
    do_reset();
    for (int n = 0; n < 4; n++) set_req(n, 1'b1, 8'(4 + n), 8'(8'h10 + n));
    for (int k = 0; k < 6; k++) begin
      step();
      check_vec($sformatf("rr_cs_%0d", k),   32'(bif.o_Bus_CS),    32'h1);
      check_vec($sformatf("rr_addr_%0d", k), 32'(bif.o_Bus_Addr8), 32'(4 + k % 4));
      step();
      check_vec($sformatf("rr_done_%0d", k), 32'(bif.o_Req_Done),  32'(1 << (k % 4)));
      step();
      check_vec($sformatf("rr_pulse_%0d", k), 32'(bif.o_Req_Done), 32'h0);
    end
    bif.i_Req = '0;
    step();

    // Read of an address with no slave.
    set_req(0, 1'b0, 8'h80, 8'h00);
    step();
    check_vec("ns_cs", 32'(bif.o_Bus_CS), 32'h1);
`ifdef BUS8_ARB_TIMEOUT_EN
    step(4);
    check_vec("to_early",   32'(bif.o_Req_Done),    32'h0);
    step();
    check_vec("to_done",    32'(bif.o_Req_Done),    32'h1);
    check_vec("to_flag",    32'(bif.o_Req_Timeout), 32'h1);
    check_vec("to_data",    32'(bif.o_Req_Rd_Data), 32'hEE);
    clr_req(0);
    step();
    check_vec("to_done_off", 32'(bif.o_Req_Done),    32'h0);
    check_vec("to_flag_off", 32'(bif.o_Req_Timeout), 32'h0);
`else
    step(20);
    check_vec("hang_done", 32'(bif.o_Req_Done),    32'h0);
    check_vec("hang_to",   32'(bif.o_Req_Timeout), 32'h0);
    stray_dv = 1'b1; stray_data = 8'h3C;
    step();
    stray_dv = 1'b0;
    check_vec("late_done", 32'(bif.o_Req_Done),    32'h1);
    check_vec("late_data", 32'(bif.o_Req_Rd_Data), 32'h3C);
    check_vec("late_to",   32'(bif.o_Req_Timeout), 32'h0);
    clr_req(0);
    step();
    check_vec("late_done_off", 32'(bif.o_Req_Done), 32'h0);
`endif
    // Following read proceeds normally (reg 5 written with 11 above).
    set_req(3, 1'b0, 8'h05, 8'h00);
    step(3);
    check_vec("after_done", 32'(bif.o_Req_Done),    32'h8);
    check_vec("after_data", 32'(bif.o_Req_Rd_Data), 32'h11);
    check_vec("after_to",   32'(bif.o_Req_Timeout), 32'h0);
    clr_req(3);
    step();

    // Reset during WAIT_RD aborts; requester 0 wins first afterwards.
    set_req(2, 1'b0, 8'h80, 8'h00);
    step(3);
    rst_n = 1'b0;
    #1;
    check_vec("ar_cs",   32'(bif.o_Bus_CS),      32'h0);
    check_vec("ar_done", 32'(bif.o_Req_Done),    32'h0);
    check_vec("ar_rd",   32'(bif.o_Req_Rd_Data), 32'h0);
    check_vec("ar_addr", 32'(bif.o_Bus_Addr8),   32'h0);
    set_req(0, 1'b1, 8'h0A, 8'h77);
    step(2);
    check_vec("ar_hold_done", 32'(bif.o_Req_Done), 32'h0);
    rst_n = 1'b1;
    step();
    check_vec("ar_win_cs",   32'(bif.o_Bus_CS),    32'h1);
    check_vec("ar_win_addr", 32'(bif.o_Bus_Addr8), 32'h0A);
    step();
    check_vec("ar_win_done", 32'(bif.o_Req_Done),  32'h1);
    bif.i_Req = '0;
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end
endmodule
